// File: rtl/edge_sense_pkg.sv
// -----------------------------------------------------------------------------
// Shared types for the edge_sense block.
//   common_p    : clock-domain bundle (clock + synchronous active-high reset).
//   clks_alot_p : edge_sense state encoding and run-time configuration record.
// No ports; compile before every other file of the block.
// -----------------------------------------------------------------------------
package common_p;

  // One clock domain: its clock and its synchronous, active-high reset.
  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;

endpackage : common_p

package clks_alot_p;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } edge_sense_state_e;

  // Width of the stable_cycles field; FILTER_WIDTH must not exceed it.
  localparam int unsigned CFG_FILTER_W = 16;

  typedef struct packed {
    logic                    polarity_en;
    logic                    polarity;     // 0 = rising selected, 1 = falling
    logic [CFG_FILTER_W-1:0] stable_cycles;
  } edge_sense_config_s;

endpackage : clks_alot_p

// File: rtl/edge_sense_sync.sv
// -----------------------------------------------------------------------------
// signal_synchronizer: multi-flop synchronizer for one asynchronous line.
//   clk     : destination clock
//   rst     : synchronous active-high reset, clears every stage
//   async_i : asynchronous input line
//   sync_o  : synchronized line (last stage)
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module signal_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // New sample enters stage 0, every other stage takes its neighbour.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule : signal_synchronizer

// File: rtl/edge_sense.sv
// -----------------------------------------------------------------------------
// edge_sense: synchronizes an external clock/data line, debounces it with a
// programmable stability filter, emits accepted-edge pulses and measures the
// edge-to-edge period.
//   sys_dom_i              : clk + synchronous active-high reset
//   sense_en_i             : enable; low forces IDLE with all outputs 0
//   clear_state_i          : return to ACQUIRE, clear counters/valid flags
//   sense_clk_i            : asynchronous line being sensed
//   polarity_en_i/_i       : select rising (0) or falling (1) polarity events
//   stable_cycles_i        : extra cycles a new level must hold
//   filtered_level_o       : accepted line level
//   rising/falling/any     : single-cycle accepted-edge pulses
//   polarity_event_o       : selected edge, or any edge when polarity is off
//   glitch_o               : candidate level reverted before acceptance
//   current_rate_counter_o : cycles since last accepted edge (saturating)
//   rate_saturated_o       : rate counter at all-ones
//   last_rate_o/_valid_o   : last edge-to-edge period and its qualifier
// -----------------------------------------------------------------------------
module edge_sense
  import common_p::*;
  import clks_alot_p::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILTER_WIDTH = 4,
  parameter int unsigned RATE_WIDTH   = 16
) (
  input  clk_dom_s                sys_dom_i,
  input  logic                    sense_en_i,
  input  logic                    clear_state_i,
  input  logic                    sense_clk_i,
  input  logic                    polarity_en_i,
  input  logic                    polarity_i,
  input  logic [FILTER_WIDTH-1:0] stable_cycles_i,
  output logic                    filtered_level_o,
  output logic                    rising_edge_o,
  output logic                    falling_edge_o,
  output logic                    any_valid_edge_o,
  output logic                    polarity_event_o,
  output logic                    glitch_o,
  output logic [RATE_WIDTH-1:0]   current_rate_counter_o,
  output logic                    rate_saturated_o,
  output logic [RATE_WIDTH-1:0]   last_rate_o,
  output logic                    last_rate_valid_o
);

  localparam logic [RATE_WIDTH-1:0]   RATE_MAX = {RATE_WIDTH{1'b1}};
  localparam logic [FILTER_WIDTH-1:0] STAB_MAX = {FILTER_WIDTH{1'b1}};

  logic clk;
  logic rst;
  logic synced;

  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.sync_rst;

  edge_sense_config_s cfg;

  always_comb begin
    cfg.polarity_en   = polarity_en_i;
    cfg.polarity      = polarity_i;
    cfg.stable_cycles = CFG_FILTER_W'(stable_cycles_i);
  end

  signal_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (sense_clk_i),
    .sync_o  (synced)
  );

  edge_sense_state_e       state_q,     state_d;
  logic                    filt_q,      filt_d;
  logic [FILTER_WIDTH-1:0] stab_q,      stab_d;
  logic                    glitch_q,    glitch_d;
  logic                    rise_q,      rise_d;
  logic                    fall_q,      fall_d;
  logic                    any_q,       any_d;
  logic                    pol_evt_q,   pol_evt_d;
  logic [RATE_WIDTH-1:0]   rate_q,      rate_d;
  logic [RATE_WIDTH-1:0]   last_rate_q, last_rate_d;
  logic                    last_vld_q,  last_vld_d;
  logic                    seen_edge_q, seen_edge_d;  // one TRACK edge already taken

  logic differ;
  logic accept;

  // The threshold is compared live, so lowering it mid-count accepts at once.
  assign differ = (synced != filt_q);
  assign accept = differ && (CFG_FILTER_W'(stab_q) >= cfg.stable_cycles);

  // NOTE: every variable gets its default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    filt_d      = filt_q;
    stab_d      = stab_q;
    glitch_d    = 1'b0;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    any_d       = 1'b0;
    pol_evt_d   = 1'b0;
    rate_d      = rate_q;
    last_rate_d = last_rate_q;
    last_vld_d  = last_vld_q;
    seen_edge_d = seen_edge_q;

    case (state_q)
      // Registers are already zero in IDLE; only leave when enabled.
      ST_IDLE: begin
        if (sense_en_i) state_d = ST_ACQUIRE;
      end

      ST_ACQUIRE, ST_TRACK: begin
        // Stability filter: a candidate that reverts while the counter is
        // nonzero is reported as a glitch.
        if (!differ) begin
          stab_d   = '0;
          glitch_d = (stab_q != '0);
        end else if (accept) begin
          stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
          stab_d = stab_q + 1'b1;
        end

        if (state_q == ST_TRACK && rate_q != RATE_MAX) begin
          rate_d = rate_q + 1'b1;
        end

        if (accept) begin
          filt_d = synced;
          rate_d = '0;
          if (state_q == ST_ACQUIRE) begin
            // First accepted level only establishes the reference.
            state_d = ST_TRACK;
          end else begin
            rise_d      = synced;
            fall_d      = !synced;
            any_d       = 1'b1;
            pol_evt_d   = cfg.polarity_en ? (cfg.polarity ? !synced : synced) : 1'b1;
            // rate_q counts from 0 in the pulse cycle, so the period is +1.
            last_rate_d = (rate_q == RATE_MAX) ? RATE_MAX : rate_q + 1'b1;
            // The first TRACK edge has no preceding edge to measure from.
            last_vld_d  = last_vld_q | seen_edge_q;
            seen_edge_d = 1'b1;
          end
        end

        // Clear overrides a coincident acceptance entirely.
        if (clear_state_i) begin
          state_d     = ST_ACQUIRE;
          filt_d      = filt_q;
          stab_d      = '0;
          glitch_d    = 1'b0;
          rise_d      = 1'b0;
          fall_d      = 1'b0;
          any_d       = 1'b0;
          pol_evt_d   = 1'b0;
          rate_d      = '0;
          last_rate_d = last_rate_q;
          last_vld_d  = 1'b0;
          seen_edge_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Disable wins from any state and zeroes every output.
    if (!sense_en_i) begin
      state_d     = ST_IDLE;
      filt_d      = 1'b0;
      stab_d      = '0;
      glitch_d    = 1'b0;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      any_d       = 1'b0;
      pol_evt_d   = 1'b0;
      rate_d      = '0;
      last_rate_d = '0;
      last_vld_d  = 1'b0;
      seen_edge_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      filt_q      <= 1'b0;
      stab_q      <= '0;
      glitch_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      any_q       <= 1'b0;
      pol_evt_q   <= 1'b0;
      rate_q      <= '0;
      last_rate_q <= '0;
      last_vld_q  <= 1'b0;
      seen_edge_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      filt_q      <= filt_d;
      stab_q      <= stab_d;
      glitch_q    <= glitch_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      any_q       <= any_d;
      pol_evt_q   <= pol_evt_d;
      rate_q      <= rate_d;
      last_rate_q <= last_rate_d;
      last_vld_q  <= last_vld_d;
      seen_edge_q <= seen_edge_d;
    end
  end

  assign filtered_level_o       = filt_q;
  assign rising_edge_o          = rise_q;
  assign falling_edge_o         = fall_q;
  assign any_valid_edge_o       = any_q;
  assign polarity_event_o       = pol_evt_q;
  assign glitch_o               = glitch_q;
  assign current_rate_counter_o = rate_q;
  assign rate_saturated_o       = (rate_q == RATE_MAX);
  assign last_rate_o            = last_rate_q;
  assign last_rate_valid_o      = last_vld_q;

endmodule : edge_sense

// File: tb/tb_edge_sense.sv
// -----------------------------------------------------------------------------
// Self-checking bench for edge_sense. A behavioural model tracks the accepted
// level, a run length of disagreeing samples, edge timestamps and an edge
// count; rate values are derived from timestamps. Directed phases cover the
// square-wave, glitch, polarity, clear, saturation and reset scenarios, plus a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_edge_sense;
  import common_p::*;
  import clks_alot_p::*;

  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int RW   = 16;
  localparam int RMAX = (1 << RW) - 1;
  localparam int SMAX = (1 << FW) - 1;

  logic          clk = 1'b0;
  logic          sync_rst;
  clk_dom_s      sys_dom;
  logic          sense_en, clear_state, sense_clk, pol_en, pol;
  logic [FW-1:0] stable;
  logic          filtered_level_o, rising_edge_o, falling_edge_o, any_valid_edge_o;
  logic          polarity_event_o, glitch_o, rate_saturated_o, last_rate_valid_o;
  logic [RW-1:0] current_rate_counter_o, last_rate_o;

  assign sys_dom.clk      = clk;
  assign sys_dom.sync_rst = sync_rst;

  always #5 clk = ~clk;

  edge_sense #(
    .SYNC_STAGES  (SYNC),
    .FILTER_WIDTH (FW),
    .RATE_WIDTH   (RW)
  ) dut (
    .sys_dom_i              (sys_dom),
    .sense_en_i             (sense_en),
    .clear_state_i          (clear_state),
    .sense_clk_i            (sense_clk),
    .polarity_en_i          (pol_en),
    .polarity_i             (pol),
    .stable_cycles_i        (stable),
    .filtered_level_o       (filtered_level_o),
    .rising_edge_o          (rising_edge_o),
    .falling_edge_o         (falling_edge_o),
    .any_valid_edge_o       (any_valid_edge_o),
    .polarity_event_o       (polarity_event_o),
    .glitch_o               (glitch_o),
    .current_rate_counter_o (current_rate_counter_o),
    .rate_saturated_o       (rate_saturated_o),
    .last_rate_o            (last_rate_o),
    .last_rate_valid_o      (last_rate_valid_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cyc = 0;          // clock edges taken so far
  bit m_pipe [SYNC];    // delayed copies of the sensed line
  int m_mode = 0;       // 0 idle, 1 acquiring, 2 tracking
  bit m_level, m_rise, m_fall, m_any, m_pol, m_glitch;
  int m_run;            // consecutive cycles the line disagreed with the level
  int m_last_rate;
  int m_edges;          // tracking edges since acquisition started
  int m_origin;         // edge index at which the rate reads 0

  function automatic int exp_rate_at(input int c);
    int r;
    if (m_mode != 2) return 0;
    r = c - m_origin;
    return (r > RMAX) ? RMAX : r;
  endfunction

  function automatic logic [39:0] exp_vec();
    int r;
    r = exp_rate_at(cyc);
    return {m_level, m_rise, m_fall, m_any, m_pol, m_glitch, (r == RMAX),
            (m_edges >= 2), 16'(m_last_rate), 16'(r)};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {filtered_level_o, rising_edge_o, falling_edge_o, any_valid_edge_o,
            polarity_event_o, glitch_o, rate_saturated_o, last_rate_valid_o,
            last_rate_o, current_rate_counter_o};
  endfunction

  task automatic model_step();
    bit syn, acc;
    int cur;
    m_rise = 0; m_fall = 0; m_any = 0; m_pol = 0; m_glitch = 0;
    if (sync_rst) begin
      foreach (m_pipe[i]) m_pipe[i] = 0;
      m_mode = 0; m_level = 0; m_run = 0; m_last_rate = 0; m_edges = 0;
    end else begin
      syn = m_pipe[SYNC-1];
      if (!sense_en) begin
        m_mode = 0; m_level = 0; m_run = 0; m_last_rate = 0; m_edges = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (clear_state) begin
        m_mode = 1; m_run = 0; m_edges = 0;
      end else begin
        cur = exp_rate_at(cyc);
        acc = (syn != m_level) && (m_run >= int'(stable));
        if (syn == m_level) begin
          m_glitch = (m_run != 0);
          m_run    = 0;
        end else if (acc) begin
          m_run = 0;
        end else begin
          m_run = (m_run < SMAX) ? m_run + 1 : SMAX;
        end
        if (acc) begin
          m_level  = syn;
          m_origin = cyc + 1;
          if (m_mode == 1) begin
            m_mode = 2;
          end else begin
            m_rise = syn;
            m_fall = !syn;
            m_any  = 1;
            m_pol  = pol_en ? (pol ? m_fall : m_rise) : m_any;
            m_last_rate = (cur + 1 > RMAX) ? RMAX : cur + 1;
            m_edges++;
          end
        end
      end
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = sense_clk;
    end
    cyc++;
  endtask

  // ---------------- cycle driver and event bookkeeping ----------------
  bit check_all = 1;
  int ntick = 0;
  int n_rise, n_fall, n_any, n_pol, n_glitch;
  int first_rise_t, last_any_t, prev_any_t, last_pol_t, prev_pol_t;

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_any = 0; n_pol = 0; n_glitch = 0;
    first_rise_t = -1; last_any_t = 0; prev_any_t = 0; last_pol_t = 0; prev_pol_t = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    ntick++;
    if (check_all) check("outs", 64'(dut_vec()), 64'(exp_vec()));
    if (rising_edge_o) begin
      if (n_rise == 0) first_rise_t = ntick;
      n_rise++;
    end
    if (falling_edge_o) n_fall++;
    if (any_valid_edge_o) begin
      n_any++; prev_any_t = last_any_t; last_any_t = ntick;
    end
    if (polarity_event_o) begin
      n_pol++; prev_pol_t = last_pol_t; last_pol_t = ntick;
    end
    if (glitch_o) n_glitch++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int t0;
  int len;

  initial begin
    sync_rst = 1'b1; sense_en = 1'b0; clear_state = 1'b0; sense_clk = 1'b0;
    pol_en = 1'b0; pol = 1'b0; stable = '0;
    clear_counts();
    @(negedge clk);

    // Reset state
    ticks(3);
    check("rst_outs", 64'(dut_vec()), 64'd0);
    check("rst_state", dut.state_q, ST_IDLE);
    sync_rst = 1'b0; sense_en = 1'b1;
    tick();
    check("en_state", dut.state_q, ST_ACQUIRE);

    // Square wave period 10, S=0, polarity off
    clear_counts();
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) sense_clk = ~sense_clk;
      tick();
    end
    check("sq_rises", n_rise, 5);
    check("sq_falls", n_fall, 6);
    check("sq_pol_any", n_pol, 11);
    check("sq_gap", last_any_t - prev_any_t, 5);
    check("sq_last_rate", last_rate_o, 16'd5);
    check("sq_valid", last_rate_valid_o, 1'b1);

    // S=3: two-cycle glitch, then a six-cycle level
    stable = 4'd3;
    ticks(4);
    clear_counts();
    sense_clk = 1'b1; ticks(2);
    sense_clk = 1'b0; ticks(10);
    check("gl_edges", n_any, 0);
    check("gl_pulses", n_glitch, 1);
    clear_counts();
    t0 = ntick;
    sense_clk = 1'b1; ticks(6);
    sense_clk = 1'b0; ticks(12);
    check("gl_rise_lat", first_rise_t - t0, 6);
    check("gl_rise_cnt", n_rise, 1);
    check("gl_fall_cnt", n_fall, 1);
    check("gl_none", n_glitch, 0);

    // Polarity: falling selected, period 8
    stable = '0; pol_en = 1'b1; pol = 1'b1;
    clear_counts();
    for (int i = 0; i < 64; i++) begin
      if (i % 4 == 0) sense_clk = ~sense_clk;
      tick();
    end
    check("pol_falls", n_fall, 8);
    check("pol_events", n_pol, 8);
    check("pol_gap", last_pol_t - prev_pol_t, 8);
    pol_en = 1'b0; pol = 1'b0;

    // Randomized phase
    for (int seg = 0; seg < 400; seg++) begin
      len = $urandom_range(1, 9);
      sense_clk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) stable = FW'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        pol_en = 1'($urandom_range(0, 1));
        pol    = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < len; k++) begin
        clear_state = ($urandom_range(0, 39) == 0);
        sense_en    = ($urandom_range(0, 199) != 0);
        tick();
      end
    end
    clear_state = 1'b0; sense_en = 1'b1; stable = '0; pol_en = 1'b0;

    // Clear coinciding with acceptance
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) sense_clk = ~sense_clk;
      tick();
    end
    check("pre_clr_state", dut.state_q, ST_TRACK);
    check("pre_clr_valid", last_rate_valid_o, 1'b1);
    sense_clk = ~sense_clk;
    ticks(2);
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    check("clr_pulse", any_valid_edge_o, 1'b0);
    check("clr_state", dut.state_q, ST_ACQUIRE);
    check("clr_valid", last_rate_valid_o, 1'b0);
    ticks(6);
    check("clr_retrack", dut.state_q, ST_TRACK);

    // Static line long enough to saturate the rate counter
    check_all = 0;
    ticks(70000);
    check_all = 1;
    tick();
    check("sat_flag", rate_saturated_o, 1'b1);
    check("sat_cnt", current_rate_counter_o, 16'hFFFF);
    sense_clk = ~sense_clk;
    ticks(4);
    check("sat_last_rate", last_rate_o, 16'hFFFF);

    // Reset in the middle of a pending candidate
    stable = 4'd3;
    clear_counts();
    sense_clk = ~sense_clk;
    ticks(3);
    sync_rst = 1'b1;
    tick();
    check("mid_rst_outs", 64'(dut_vec()), 64'd0);
    check("mid_rst_state", dut.state_q, ST_IDLE);
    check("mid_rst_sync", 64'(dut.u_sync.sync_q), 64'd0);
    sync_rst = 1'b0;
    tick();
    check("rearm_state", dut.state_q, ST_ACQUIRE);
    ticks(5);
    check("mid_rst_glitch", n_glitch, 0);

    // Disable forces IDLE with zero outputs
    sense_en = 1'b0;
    tick();
    check("dis_outs", 64'(dut_vec()), 64'd0);
    check("dis_state", dut.state_q, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_edge_sense
